// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings and the multiply/divide FSM state type,
// used by the mul/div unit and the datapath ALU decoder.
package alu_pkg;

    localparam int OPW_DEFAULT = 3;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULH  = 3'd1,
        OP_MULHU = 3'd2,
        OP_DIV   = 3'd4,
        OP_MOD   = 3'd5,
        OP_DIVU  = 3'd6,
        OP_MODU  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_shifted,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // When the subtraction succeeds the true difference is below the divisor,
    // so the low WIDTH bits of the subtraction are exact.
    always_comb begin
        q_bit    = (rem_shifted >= {1'b0, divisor});
        rem_next = q_bit ? (rem_shifted[WIDTH-1:0] - divisor) : rem_shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit: one prep cycle to take magnitudes,
// then WIDTH shift-add or restoring shift-subtract steps, sign fixup on the last.
module mul_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = OPW_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_divzero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [OPW-1:0] C_MUL   = OPW'(OP_MUL);
    localparam logic [OPW-1:0] C_MULH  = OPW'(OP_MULH);
    localparam logic [OPW-1:0] C_MULHU = OPW'(OP_MULHU);
    localparam logic [OPW-1:0] C_DIV   = OPW'(OP_DIV);
    localparam logic [OPW-1:0] C_MOD   = OPW'(OP_MOD);
    localparam logic [OPW-1:0] C_DIVU  = OPW'(OP_DIVU);
    localparam logic [OPW-1:0] C_MODU  = OPW'(OP_MODU);

    md_state_e          state_reg;
    logic [CW-1:0]      cnt_reg;
    logic               prep_reg;
    logic [OPW-1:0]     op_reg;
    logic [WIDTH-1:0]   src1_reg, src2_reg, a_reg, hi_reg, lo_reg;
    logic               prod_neg_reg, q_neg_reg, r_neg_reg, dz_reg;
    logic               in_ready_reg, out_valid_reg, divzero_reg;
    logic [WIDTH-1:0]   result_reg;

    logic is_mul, is_mulh, is_mulhu, is_div, is_mod, is_divu, is_modu;
    logic div_op, signed_div, s1, s2;

    assign is_mul     = (op_reg == C_MUL);
    assign is_mulh    = (op_reg == C_MULH);
    assign is_mulhu   = (op_reg == C_MULHU);
    assign is_div     = (op_reg == C_DIV);
    assign is_mod     = (op_reg == C_MOD);
    assign is_divu    = (op_reg == C_DIVU);
    assign is_modu    = (op_reg == C_MODU);
    assign div_op     = is_div | is_mod | is_divu | is_modu;
    assign signed_div = is_div | is_mod;
    assign s1         = src1_reg[WIDTH-1];
    assign s2         = src2_reg[WIDTH-1];

    logic [WIDTH-1:0] mag1, mag2;
    assign mag1 = ((is_mulh | signed_div) & s1) ? -src1_reg : src1_reg;
    assign mag2 = ((is_mulh | signed_div) & s2) ? -src2_reg : src2_reg;

    // Multiply: LSB-first shift-add into {hi, lo}, multiplier consumed from lo.
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);

    // Divide: dividend bits leave lo at the top, quotient bits enter at the bottom.
    logic [WIDTH-1:0] div_rem;
    logic             div_q;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_shifted ({hi_reg, lo_reg[WIDTH-1]}),
        .divisor     (a_reg),
        .rem_next    (div_rem),
        .q_bit       (div_q)
    );

    logic [WIDTH-1:0]   step_hi, step_lo, quot, rem, final_result;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign step_hi  = div_op ? div_rem : mul_sum[WIDTH:1];
    assign step_lo  = div_op ? {lo_reg[WIDTH-2:0], div_q} : {mul_sum[0], lo_reg[WIDTH-1:1]};
    assign prod     = {step_hi, step_lo};
    assign prod_fix = prod_neg_reg ? -prod : prod;
    assign quot     = q_neg_reg ? -step_lo : step_lo;
    assign rem      = r_neg_reg ? -step_hi : step_hi;

    always_comb begin
        final_result = '0;
        if (is_mul)
            final_result = prod_fix[WIDTH-1:0];
        else if (is_mulh)
            final_result = prod_fix[2*WIDTH-1:WIDTH];
        else if (is_mulhu)
            final_result = prod[2*WIDTH-1:WIDTH];
        else if (is_div | is_divu)
            final_result = dz_reg ? '1 : quot;
        else if (is_mod | is_modu)
            final_result = dz_reg ? src1_reg : rem;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            prep_reg      <= 1'b0;
            op_reg        <= '0;
            src1_reg      <= '0;
            src2_reg      <= '0;
            a_reg         <= '0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            prod_neg_reg  <= 1'b0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            dz_reg        <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            divzero_reg   <= 1'b0;
        end else if (flush) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            prep_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            divzero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (in_valid) begin
                    op_reg       <= in_op;
                    src1_reg     <= in_src1;
                    src2_reg     <= in_src2;
                    cnt_reg      <= CW'(WIDTH);
                    prep_reg     <= 1'b1;
                    in_ready_reg <= 1'b0;
                    state_reg    <= ST_BUSY;
                end
                ST_BUSY: if (prep_reg) begin
                    prep_reg     <= 1'b0;
                    hi_reg       <= '0;
                    a_reg        <= div_op ? mag2 : mag1;
                    lo_reg       <= div_op ? mag1 : mag2;
                    prod_neg_reg <= is_mulh & (s1 ^ s2);
                    q_neg_reg    <= signed_div & (s1 ^ s2);
                    r_neg_reg    <= signed_div & s1;
                    dz_reg       <= div_op & (src2_reg == '0);
                end else begin
                    hi_reg  <= step_hi;
                    lo_reg  <= step_lo;
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        result_reg    <= final_result;
                        divzero_reg   <= dz_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: if (out_ready) begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign out_result  = result_reg;
    assign out_divzero = divzero_reg;

endmodule
